mem_stage_sram: RTL

// - MEM stage of the ARM pipeline: sits between EXE_Reg and MEM_Reg and services LDR/STR on the off-chip 16-bit SRAM.
// - Each 32-bit word is moved as two 16-bit halves, with a fixed number of wait cycles per half.
// - ready=0 while an access is in flight; the top level uses ~ready as the freeze for IF/ID/EXE/MEM pipeline registers.

---
 rtl/mem_stage_sram.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: MEM stage load/store engine for a 16-bit asynchronous SRAM.
// Each 32-bit word is transferred as two half-word accesses (low half first),
// each held for WAIT_CYCLES clocks. ready low freezes the upstream pipeline.
`timescale 1ns/1ps
module mem_stage_sram #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_res,
    input  logic [31:0]        val_rm,
    output logic [31:0]        mem_rdata,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    // Counter wide enough for 0..WAIT_CYCLES-1 (at least one bit).
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [SRAM_AW-2:0] addr_q;       // latched word address
    logic [15:0]        data_hi_q;    // upper store half, driven once LOW ends
    logic               wr_q;         // latched op: 1 = store
    logic               we_n_q;
    logic               dq_oe_q;
    logic [15:0]        dq_out_q;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic [31:0]        mem_rdata_q;

    logic               req_d;
    logic [SRAM_AW-2:0] waddr_d;

    // Request decode and word address; addresses below the base simply wrap.
    assign req_d   = mem_r_en | mem_w_en;
    assign waddr_d = (SRAM_AW-1)'((alu_res - 32'(ADDR_BASE)) >> 2);

    // Access sequencer: latches the request, walks both halves, then releases the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_hi_q   <= '0;
            wr_q        <= 1'b0;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
            sram_addr_q <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_d) begin
                        // A simultaneous load+store request is a store.
                        state_q     <= S_LOW;
                        cnt_q       <= '0;
                        addr_q      <= waddr_d;
                        data_hi_q   <= val_rm[31:16];
                        wr_q        <= mem_w_en;
                        we_n_q      <= ~mem_w_en;
                        dq_oe_q     <= mem_w_en;
                        dq_out_q    <= val_rm[15:0];
                        sram_addr_q <= {waddr_d, 1'b0};
                    end
                end
                S_LOW: begin
                    if (cnt_q == CNT_LAST) begin
                        if (!wr_q) begin
                            mem_rdata_q[15:0] <= SRAM_DQ;
                        end
                        state_q     <= S_HIGH;
                        cnt_q       <= '0;
                        dq_out_q    <= data_hi_q;
                        sram_addr_q <= {addr_q, 1'b1};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (cnt_q == CNT_LAST) begin
                        if (!wr_q) begin
                            mem_rdata_q[31:16] <= SRAM_DQ;
                        end
                        state_q <= S_DONE;
                        cnt_q   <= '0;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // Pipeline advances on this edge; any request here is the old one.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // In IDLE the pipeline only stalls if a new access is being requested.
    assign ready     = (state_q == S_DONE) || ((state_q == S_IDLE) && !req_d);
    assign mem_rdata = mem_rdata_q;

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
